// File: rtl/conv1_buf_ctrl.sv
// Frame sequencer for the layer-1 conv window buffer: raster-reads one image from
// single-port memory, streams pixels downstream and flags complete windows.
module conv1_buf_ctrl #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 8,
    parameter int ADDR_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 out_ready,
    output logic                 img_rd_en,
    output logic [ADDR_BITS-1:0] img_addr,
    input  logic [DATA_BITS-1:0] img_data,
    output logic [DATA_BITS-1:0] pix_out,
    output logic                 pix_valid,
    output logic                 win_valid,
    output logic [4:0]           win_row,
    output logic [4:0]           win_col,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [4:0]           COL_LAST  = 5'(WIDTH - 1);
    localparam logic [4:0]           ROW_LAST  = 5'(HEIGHT - 1);
    localparam logic [4:0]           WIN_OFS   = 5'(FILTER_SIZE - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 frame_start;
    logic [ADDR_BITS-1:0] rd_cnt;
    logic [4:0]           prow;
    logic [4:0]           pcol;

    // Handshake: a read issues only while out_ready=1; its pixel appears with
    // pix_valid exactly one cycle later regardless of out_ready, so downstream
    // must absorb one beat after dropping out_ready.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        img_rd_en   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = FETCH;
                    frame_start = 1'b1;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                img_rd_en = out_ready;
                if (out_ready && rd_cnt == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            pix_valid <= 1'b0;
            prow      <= '0;
            pcol      <= '0;
        end else begin
            state     <= state_nxt;
            pix_valid <= img_rd_en;

            if (frame_start) begin
                rd_cnt <= '0;
            end else if (img_rd_en) begin
                rd_cnt <= rd_cnt + ADDR_BITS'(1);
            end

            // Position tracks the pixel currently on pix_out; it steps after acceptance.
            if (frame_start) begin
                prow <= '0;
                pcol <= '0;
            end else if (pix_valid) begin
                if (pcol == COL_LAST) begin
                    pcol <= '0;
                    prow <= (prow == ROW_LAST) ? 5'd0 : prow + 5'd1;
                end else begin
                    pcol <= pcol + 5'd1;
                end
            end
        end
    end

    assign img_addr  = img_rd_en ? rd_cnt : '0;
    assign pix_out   = img_data;
    assign win_valid = pix_valid && (prow >= WIN_OFS) && (pcol >= WIN_OFS);
    assign win_row   = win_valid ? prow - WIN_OFS : 5'd0;
    assign win_col   = win_valid ? pcol - WIN_OFS : 5'd0;
    assign state_dbg = state;

endmodule

// File: tb/tb_conv1_buf_ctrl.sv
// Scoreboarded bench for conv1_buf_ctrl: frame stimulus pushes expected pixel/window
// beats, a negedge monitor pops and compares, per-frame timing stats are checked after.
module tb_conv1_buf_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       out_ready;
    logic       img_rd_en;
    logic [9:0] img_addr;
    logic [7:0] img_data;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       win_valid;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    conv1_buf_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .out_ready (out_ready),
        .img_rd_en (img_rd_en),
        .img_addr  (img_addr),
        .img_data  (img_data),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / memory model ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_val(input int a);
        return 8'(a * 37 + (a >> 3) + 5);
    endfunction

    initial img_data = 8'h00;
    always @(posedge clk) if (img_rd_en) img_data <= mem_val(int'(img_addr));

    // ---------------- scoreboard state ----------------
    logic [18:0] exp_q[$];
    logic [18:0] exp_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;
    bit  prev_rd  = 1'b0;
    bit  prev_rst = 1'b1;
    int  t0       = 0;
    int  rel;
    int  exp_addr;
    int  first_rd, last_rd, first_rd_abs, first_pix, last_pix, first_busy, busy_cnt;
    int  pix_cnt, win_cnt, first_win, last_win, done_cnt, done_rel, done_abs;
    bit  done_seen;
    logic [15:0] lfsr = 16'hACE1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [18:0] make_exp(input int i);
        int r, c;
        logic w;
        r = i / 28;
        c = i % 28;
        w = (r >= 4) && (c >= 4);
        return {w, w ? 5'(r - 4) : 5'd0, w ? 5'(c - 4) : 5'd0, mem_val(i)};
    endfunction

    task automatic reset_stats();
        exp_addr  = 0;
        first_rd  = -1; last_rd = -1; first_rd_abs = -1;
        first_pix = -1; last_pix = -1; first_busy = -1; busy_cnt = 0;
        pix_cnt   = 0; win_cnt = 0; first_win = -1; last_win = -1;
        done_cnt  = 0; done_rel = -1; done_abs = -1; done_seen = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc - t0;
            check("pix_valid_pipe", 32'(pix_valid), prev_rst ? 32'd0 : 32'(prev_rd));
            prev_rd  = img_rd_en;
            prev_rst = rst_n;
            if (!out_ready) check("rd_gated", 32'(img_rd_en), 32'd0);
            if (img_rd_en) begin
                check("rd_addr", 32'(img_addr), 32'(exp_addr));
                exp_addr++;
                if (first_rd < 0) begin
                    first_rd     = rel;
                    first_rd_abs = cyc;
                end
                last_rd = rel;
            end
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = rel;
            end
            if (pix_valid) begin
                pix_cnt++;
                if (first_pix < 0) first_pix = rel;
                last_pix = rel;
                if (win_valid) begin
                    win_cnt++;
                    if (first_win < 0) first_win = rel;
                    last_win = rel;
                end
                check("pix_q_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("pix_beat", 32'({win_valid, win_row, win_col, pix_out}), 32'(exp_e));
                end
            end else begin
                check("win_idle", 32'({win_valid, win_row, win_col}), 32'd0);
            end
            if (done) begin
                done_cnt++;
                done_rel  = rel;
                done_abs  = cyc;
                done_seen = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_lfsr();
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
            step_lfsr();
            out_ready = lfsr[0];
        end
    endtask

    // Called just after a posedge; asserts start for the current cycle.
    task automatic start_frame(input int n_exp);
        reset_stats();
        for (int i = 0; i < n_exp; i++) exp_q.push_back(make_exp(i));
        t0        = cyc;
        start     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic run_until_done(input int mode, input int start_at, input int rst_at,
                                  input int budget);
        int n;
        bit aborted;
        n = 0;
        aborted = 1'b0;
        forever begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            rst_n = 1'b0;
            if (done_seen || aborted || n > budget) break;
            step_lfsr();
            out_ready = (mode == 0) ? 1'b1 : lfsr[0];
            if (cyc - t0 == start_at) start = 1'b1;
            if (cyc - t0 == rst_at) begin
                rst_n   = 1'b1;
                aborted = 1'b1;
            end
        end
        check("frame_end", 32'(done_seen || aborted), 32'd1);
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({img_rd_en, img_addr, pix_valid, win_valid, win_row, win_col,
                         busy, done, state_dbg}), 32'd0);
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_pix_cnt"}, 32'(pix_cnt), 32'd784);
        check({tag, "_win_cnt"}, 32'(win_cnt), 32'd576);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e_done_abs;
        rst_n     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        reset_stats();
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_zero("reset_state");
        idle_cycles(3);

        // A: continuous out_ready, exact timing
        start_frame(784);
        run_until_done(0, -1, -1, 3000);
        check("A_first_rd", 32'(first_rd), 32'd1);
        check("A_last_rd", 32'(last_rd), 32'd784);
        check("A_first_pix", 32'(first_pix), 32'd2);
        check("A_last_pix", 32'(last_pix), 32'd785);
        check("A_first_busy", 32'(first_busy), 32'd1);
        check("A_busy_cnt", 32'(busy_cnt), 32'd785);
        check("A_done_rel", 32'(done_rel), 32'd786);
        check("A_first_win", 32'(first_win), 32'd118);
        check("A_last_win", 32'(last_win), 32'd785);
        check_totals("A");
        idle_cycles(4);
        @(negedge clk);
        check("A_idle_state", 32'(state_dbg), 32'd0);

        // B: pseudo-random back-pressure
        start_frame(784);
        run_until_done(1, -1, -1, 8000);
        check_totals("B");
        check("B_rd_total", 32'(exp_addr), 32'd784);
        idle_cycles(4);

        // C: start pulsed mid-frame at rd_cnt=300 must be ignored
        start_frame(784);
        run_until_done(0, 301, -1, 3000);
        check_totals("C");
        check("C_done_rel", 32'(done_rel), 32'd786);
        idle_cycles(6);
        @(negedge clk);
        check("C_no_restart", 32'(exp_addr), 32'd784);

        // D: one-cycle reset at rd_cnt=500 aborts the frame
        start_frame(500);
        run_until_done(0, -1, 501, 3000);
        @(negedge clk);
        check_zero("D_after_reset");
        check("D_pix_cnt", 32'(pix_cnt), 32'd500);
        check("D_q_empty", 32'(exp_q.size()), 32'd0);
        check("D_no_done", 32'(done_cnt), 32'd0);
        idle_cycles(3);
        check("D_still_no_done", 32'(done_cnt), 32'd0);

        // E then F back-to-back, start in the cycle right after done
        start_frame(784);
        run_until_done(1, -1, -1, 8000);
        check_totals("E");
        e_done_abs = done_abs;
        start_frame(784);
        run_until_done(0, -1, -1, 3000);
        check_totals("F");
        check("F_first_rd", 32'(first_rd), 32'd1);
        check("F_gap_after_done", 32'(first_rd_abs - e_done_abs), 32'd2);
        idle_cycles(4);
        @(negedge clk);
        check("F_idle_state", 32'(state_dbg), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
